// File: rtl/tile_pkg.sv
// Shared types and constants for the 16-tile memory-matching game controller.
package tile_pkg;

  localparam int unsigned N_TILES    = 16;
  localparam int unsigned N_PAIRS    = 8;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned TILE_VAL_W = 3;

  typedef logic [TILE_VAL_W-1:0] tile_val_t;

  typedef enum logic [1:0] {
    S_FIRST,
    S_SECOND,
    S_SHOW,
    S_WIN
  } state_e;

endpackage

// File: rtl/key_pulse.sv
// Two-flop synchroniser for a raw active-low button plus a history flop;
// emits a one-cycle pulse on each synchronised falling edge.
module key_pulse (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic s1_q, s2_q, s3_q;

  // Reset to the released level so that leaving reset never fakes a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= key_n;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign press = s3_q & ~s2_q;

endmodule

// File: rtl/tile_match_ctrl.sv
// Sequencing controller for the memory-matching game: takes two tile picks,
// reveals them for SHOW_CYCLES, then scores the pair and tracks progress.
module tile_match_ctrl
  import tile_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = 50_000_000,
  parameter int unsigned VAL_W       = 3,
  parameter int unsigned MOVE_MAX    = 99
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             key_sel_n,
  input  logic [3:0]       sel_idx,
  input  logic [VAL_W-1:0] tile_val,
  output logic [3:0]       rd_idx,
  output logic [VAL_W-1:0] first_val,
  output logic             first_valid,
  output logic [VAL_W-1:0] second_val,
  output logic             second_valid,
  output logic [15:0]      matched,
  output logic [3:0]       pairs,
  output logic [6:0]       moves,
  output logic             busy,
  output logic             win
);

  localparam int unsigned TW = $clog2(SHOW_CYCLES);

  logic press;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [IDX_W-1:0]     first_idx_q, first_idx_d;
  logic [IDX_W-1:0]     second_idx_q, second_idx_d;
  logic [VAL_W-1:0]     first_val_q, first_val_d;
  logic [VAL_W-1:0]     second_val_q, second_val_d;
  logic                 first_valid_q, first_valid_d;
  logic                 second_valid_q, second_valid_d;
  logic [N_TILES-1:0]   matched_q, matched_d;
  logic [3:0]           pairs_q, pairs_d;
  logic [6:0]           moves_q, moves_d;

  key_pulse u_key_pulse (
    .clk   (CLOCK_50),
    .reset (reset),
    .key_n (key_sel_n),
    .press (press)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= S_FIRST;
      timer_q        <= '0;
      first_idx_q    <= '0;
      second_idx_q   <= '0;
      first_val_q    <= '0;
      second_val_q   <= '0;
      first_valid_q  <= 1'b0;
      second_valid_q <= 1'b0;
      matched_q      <= '0;
      pairs_q        <= '0;
      moves_q        <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      first_idx_q    <= first_idx_d;
      second_idx_q   <= second_idx_d;
      first_val_q    <= first_val_d;
      second_val_q   <= second_val_d;
      first_valid_q  <= first_valid_d;
      second_valid_q <= second_valid_d;
      matched_q      <= matched_d;
      pairs_q        <= pairs_d;
      moves_q        <= moves_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    first_idx_d    = first_idx_q;
    second_idx_d   = second_idx_q;
    first_val_d    = first_val_q;
    second_val_d   = second_val_q;
    first_valid_d  = first_valid_q;
    second_valid_d = second_valid_q;
    matched_d      = matched_q;
    pairs_d        = pairs_q;
    moves_d        = moves_q;

    unique case (state_q)
      S_FIRST: begin
        if (press && !matched_q[sel_idx]) begin
          first_idx_d   = sel_idx;
          first_val_d   = tile_val;
          first_valid_d = 1'b1;
          state_d       = S_SECOND;
        end
      end
      S_SECOND: begin
        if (press && !matched_q[sel_idx] && (sel_idx != first_idx_q)) begin
          second_idx_d   = sel_idx;
          second_val_d   = tile_val;
          second_valid_d = 1'b1;
          timer_d        = TW'(SHOW_CYCLES - 1);
          state_d        = S_SHOW;
        end
      end
      S_SHOW: begin
        // Presses are dropped here, including one landing on the exit cycle.
        if (timer_q == '0) begin
          if (first_val_q == second_val_q) begin
            matched_d[first_idx_q]  = 1'b1;
            matched_d[second_idx_q] = 1'b1;
            pairs_d                 = pairs_q + 4'd1;
          end
          moves_d        = (moves_q >= 7'(MOVE_MAX)) ? 7'(MOVE_MAX) : moves_q + 7'd1;
          first_valid_d  = 1'b0;
          second_valid_d = 1'b0;
          first_val_d    = '0;
          second_val_d   = '0;
          state_d        = (pairs_d == 4'(N_PAIRS)) ? S_WIN : S_FIRST;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_WIN: begin
      end
      default: state_d = S_FIRST;
    endcase
  end

  assign rd_idx       = sel_idx;
  assign first_val    = first_val_q;
  assign first_valid  = first_valid_q;
  assign second_val   = second_val_q;
  assign second_valid = second_valid_q;
  assign matched      = matched_q;
  assign pairs        = pairs_q;
  assign moves        = moves_q;
  assign busy         = (state_q == S_SHOW);
  assign win          = (state_q == S_WIN);

endmodule

// File: tb/tb_tile_match_ctrl.sv
// Directed bench for tile_match_ctrl with a 4-cycle reveal and a ROM where
// tile idx holds value idx>>1, so tiles 2k and 2k+1 form a pair.
module tb_tile_match_ctrl;
  import tile_pkg::*;

  logic            clk;
  logic            reset;
  logic            key_sel_n;
  logic [3:0]      sel_idx;
  tile_val_t       tile_val;
  logic [3:0]      rd_idx;
  tile_val_t       first_val;
  logic            first_valid;
  tile_val_t       second_val;
  logic            second_valid;
  logic [15:0]     matched;
  logic [3:0]      pairs;
  logic [6:0]      moves;
  logic            busy;
  logic            win;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  tile_match_ctrl #(
    .SHOW_CYCLES (4),
    .VAL_W       (3),
    .MOVE_MAX    (99)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .key_sel_n    (key_sel_n),
    .sel_idx      (sel_idx),
    .tile_val     (tile_val),
    .rd_idx       (rd_idx),
    .first_val    (first_val),
    .first_valid  (first_valid),
    .second_val   (second_val),
    .second_valid (second_valid),
    .matched      (matched),
    .pairs        (pairs),
    .moves        (moves),
    .busy         (busy),
    .win          (win)
  );

  // Test ROM driven from the sel index the bench itself applies.
  assign tile_val = tile_val_t'(sel_idx >> 1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full press/release; long enough that a second pick also finishes its reveal.
  task automatic do_press(input logic [3:0] idx);
    sel_idx   = idx;
    key_sel_n = 1'b0;
    tick(3);
    key_sel_n = 1'b1;
    tick(4);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    key_sel_n = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    key_sel_n = 1'b1;
    sel_idx   = 4'd0;
    tick(1);
    do_reset();

    chk("rst_first_valid", 32'(first_valid), 32'd0);
    chk("rst_second_valid", 32'(second_valid), 32'd0);
    chk("rst_matched", 32'(matched), 32'h0);
    chk("rst_pairs", 32'(pairs), 32'd0);
    chk("rst_moves", 32'(moves), 32'd0);
    chk("rst_busy_win", {busy, win}, 32'd0);
    sel_idx = 4'd9;
    #1;
    chk("rd_idx_follows", 32'(rd_idx), 32'd9);

    // First pick shows up three edges after the key falls.
    sel_idx   = 4'd0;
    key_sel_n = 1'b0;
    tick(3);
    chk("first_valid_lat", 32'(first_valid), 32'd1);
    chk("first_val_0", 32'(first_val), 32'd0);
    key_sel_n = 1'b1;
    tick(4);

    // Second pick: reveal lasts exactly 4 busy cycles.
    sel_idx   = 4'd1;
    key_sel_n = 1'b0;
    tick(3);
    chk("busy_start", 32'(busy), 32'd1);
    chk("second_valid", 32'(second_valid), 32'd1);
    chk("second_val_0", 32'(second_val), 32'd0);
    tick(3);
    chk("busy_last", 32'(busy), 32'd1);
    tick(1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("match_mask", 32'(matched), 32'h0003);
    chk("match_pairs", 32'(pairs), 32'd1);
    chk("match_moves", 32'(moves), 32'd1);
    chk("match_valids", {first_valid, second_valid}, 32'd0);
    key_sel_n = 1'b1;
    tick(4);

    // Mismatch 2/4.
    do_press(4'd2);
    do_press(4'd4);
    chk("miss_mask", 32'(matched), 32'h0003);
    chk("miss_pairs", 32'(pairs), 32'd1);
    chk("miss_moves", 32'(moves), 32'd2);
    chk("miss_first_valid", 32'(first_valid), 32'd0);

    // Pick on matched tile is ignored; same tile twice is ignored.
    do_press(4'd0);
    chk("ign_matched", 32'(first_valid), 32'd0);
    do_press(4'd2);
    chk("pick2_valid", 32'(first_valid), 32'd1);
    chk("pick2_val", 32'(first_val), 32'd1);
    do_press(4'd2);
    chk("ign_same_sv", 32'(second_valid), 32'd0);
    chk("ign_same_busy", 32'(busy), 32'd0);

    // Pick 3, then a press that lands on the reveal exit cycle.
    sel_idx   = 4'd3;
    key_sel_n = 1'b0;
    tick(3);
    chk("p3_busy", 32'(busy), 32'd1);
    key_sel_n = 1'b1;
    tick(1);
    sel_idx   = 4'd5;
    key_sel_n = 1'b0;
    tick(3);
    chk("exit_busy", 32'(busy), 32'd0);
    chk("exit_mask", 32'(matched), 32'h000F);
    chk("exit_pairs", 32'(pairs), 32'd2);
    chk("exit_moves", 32'(moves), 32'd3);
    chk("exit_press_ign", 32'(first_valid), 32'd0);
    key_sel_n = 1'b1;
    tick(4);
    chk("exit_press_ign2", 32'(first_valid), 32'd0);

    // Remaining pairs; the last one is stepped to see win timing.
    for (int k = 2; k < 7; k++) begin
      do_press(4'(2 * k));
      do_press(4'(2 * k + 1));
    end
    chk("pre_win_pairs", 32'(pairs), 32'd7);
    do_press(4'd14);
    sel_idx   = 4'd15;
    key_sel_n = 1'b0;
    tick(3);
    key_sel_n = 1'b1;
    tick(3);
    chk("win_not_yet", {busy, win}, 32'b10);
    tick(1);
    chk("win_high", 32'(win), 32'd1);
    chk("win_mask", 32'(matched), 32'hFFFF);
    chk("win_pairs", 32'(pairs), 32'd8);
    chk("win_moves", 32'(moves), 32'd9);
    tick(4);
    do_press(4'd0);
    do_press(4'd1);
    chk("win_hold", 32'(win), 32'd1);
    chk("win_hold_fv", 32'(first_valid), 32'd0);
    chk("win_hold_moves", 32'(moves), 32'd9);

    // Reset in the second S_SHOW cycle aborts the comparison.
    do_reset();
    chk("rst_from_win", 32'(win), 32'd0);
    do_press(4'd0);
    sel_idx   = 4'd1;
    key_sel_n = 1'b0;
    tick(4);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mask", 32'(matched), 32'h0);
    chk("abort_pairs", 32'(pairs), 32'd0);
    chk("abort_moves", 32'(moves), 32'd0);
    chk("abort_valids", {first_valid, second_valid}, 32'd0);
    key_sel_n = 1'b1;
    reset     = 1'b0;
    tick(4);

    // Move counter saturation.
    for (int i = 0; i < 98; i++) begin
      do_press(4'd0);
      do_press(4'd2);
    end
    chk("moves_98", 32'(moves), 32'd98);
    do_press(4'd0);
    do_press(4'd2);
    chk("moves_99", 32'(moves), 32'd99);
    for (int i = 0; i < 21; i++) begin
      do_press(4'd0);
      do_press(4'd2);
    end
    chk("moves_sat", 32'(moves), 32'd99);
    chk("sat_pairs", 32'(pairs), 32'd0);
    chk("sat_mask", 32'(matched), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
